// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle sequencer.
// Opcodes, FSM state encoding and instruction field helpers.
package proc_pkg;

  // Widest instruction word the field helpers accept.
  localparam int MAX_IW = 64;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_HALT = 4'b0111;
  localparam logic [3:0] OP_LOAD = 4'b1000;
  localparam logic [3:0] OP_INC  = 4'b1010;
  localparam logic [3:0] OP_DEC  = 4'b1011;
  localparam logic [3:0] OP_JZ   = 4'b1110;
  localparam logic [3:0] OP_JMP  = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALTED
  } state_t;

  // Top nibble of a DATA_W+8 wide word.
  function automatic logic [3:0] f_op(
    input logic [MAX_IW-1:0] ir,
    input int                dw
  );
    return 4'(ir >> (dw + 4));
  endfunction

  // Register field of width raw starting at bit lsb.
  function automatic logic [3:0] f_reg(
    input logic [MAX_IW-1:0] ir,
    input int                lsb,
    input int                raw
  );
    logic [MAX_IW-1:0] mask;
    mask = (MAX_IW'(1) << raw) - MAX_IW'(1);
    return 4'((ir >> lsb) & mask);
  endfunction

endpackage

// File: rtl/proc_regfile.sv
// Register file: NREG x DATA_W, one sync write port, sync clear.
// Ports: we/waddr/wdata write; ra, rb, dbg combinational reads.
module proc_regfile #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [RA_W-1:0]   rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 2 ** RA_W;

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data  = regs[ra_addr];
  assign rb_data  = regs[rb_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/proc_seq.sv
// Fetch/decode/execute sequencer: FSM, ALU, PC, flags.
// Ports: clk/rst, start, imem_*, busy/halted/retire/illegal, flags, dbg.
module proc_seq
  import proc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_en,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [DATA_W+7:0] imem_rdata,
  output logic              busy,
  output logic              halted,
  output logic              retire,
  output logic              illegal,
  output logic              zero_flag,
  output logic              carry_flag,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int IW = DATA_W + 8;

  state_t state;
  state_t state_n;

  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_n;
  logic [IW-1:0]     ir;
  logic              zf;
  logic              cf;
  logic              zf_n;
  logic              cf_n;

  logic [MAX_IW-1:0] ir_x;
  logic [3:0]        op;
  logic [RA_W-1:0]   rd;
  logic [RA_W-1:0]   rs;
  logic [RA_W-1:0]   rt;
  logic [DATA_W-1:0] imm;
  logic [PC_W-1:0]   jt;

  logic is_add;
  logic is_sub;
  logic is_and;
  logic is_or;
  logic is_halt;
  logic is_load;
  logic is_inc;
  logic is_dec;
  logic is_jz;
  logic is_jmp;

  logic [RA_W-1:0]   rb_addr;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W:0]   sum;
  logic              alu_we;
  logic              upd;
  logic              ill_op;
  logic              rf_we;

  // Field extraction
  assign ir_x = MAX_IW'(ir);
  assign op   = f_op(ir_x, DATA_W);
  assign rd   = RA_W'(f_reg(ir_x, DATA_W, RA_W));
  assign rs   = RA_W'(f_reg(ir_x, DATA_W / 2, RA_W));
  assign rt   = RA_W'(f_reg(ir_x, 0, RA_W));
  assign imm  = ir[DATA_W-1:0];
  assign jt   = PC_W'(imm);

  assign is_add  = (op == OP_ADD);
  assign is_sub  = (op == OP_SUB);
  assign is_and  = (op == OP_AND);
  assign is_or   = (op == OP_OR);
  assign is_halt = (op == OP_HALT);
  assign is_load = (op == OP_LOAD);
  assign is_inc  = (op == OP_INC);
  assign is_dec  = (op == OP_DEC);
  assign is_jz   = (op == OP_JZ);
  assign is_jmp  = (op == OP_JMP);

  // INC/DEC operate on rd, so the second read port follows rd then.
  assign rb_addr = (is_inc | is_dec) ? rd : rt;
  assign rf_we   = (state == S_EXEC) & alu_we;

  proc_regfile #(
    .DATA_W (DATA_W),
    .RA_W   (RA_W)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rd),
    .wdata    (sum[DATA_W-1:0]),
    .ra_addr  (rs),
    .ra_data  (a),
    .rb_addr  (rb_addr),
    .rb_data  (b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // ALU and next-PC; sum[DATA_W] is carry or borrow.
  always_comb begin
    sum    = '0;
    alu_we = 1'b0;
    upd    = 1'b0;
    ill_op = 1'b0;
    pc_n   = pc + PC_W'(1);
    unique case (1'b1)
      is_add: begin
        sum    = {1'b0, a} + {1'b0, b};
        alu_we = 1'b1;
        upd    = 1'b1;
      end
      is_sub: begin
        sum    = {1'b0, a} - {1'b0, b};
        alu_we = 1'b1;
        upd    = 1'b1;
      end
      is_and: begin
        sum    = {1'b0, a & b};
        alu_we = 1'b1;
        upd    = 1'b1;
      end
      is_or: begin
        sum    = {1'b0, a | b};
        alu_we = 1'b1;
        upd    = 1'b1;
      end
      is_inc: begin
        sum    = {1'b0, b} + {{DATA_W{1'b0}}, 1'b1};
        alu_we = 1'b1;
        upd    = 1'b1;
      end
      is_dec: begin
        sum    = {1'b0, b} - {{DATA_W{1'b0}}, 1'b1};
        alu_we = 1'b1;
        upd    = 1'b1;
      end
      is_load: begin
        sum    = {1'b0, imm};
        alu_we = 1'b1;
      end
      is_halt: pc_n = pc;
      is_jz: begin
        if (zf) pc_n = jt;
      end
      is_jmp: pc_n = jt;
      default: ill_op = 1'b1;
    endcase
    zf_n = upd ? (sum[DATA_W-1:0] == '0) : zf;
    cf_n = upd ? sum[DATA_W] : cf;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (start) state_n = S_FETCH;
      S_HALTED: if (start) state_n = S_FETCH;
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: state_n = S_EXEC;
      S_EXEC:   state_n = is_halt ? S_HALTED : S_FETCH;
      default:  state_n = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    imem_en = (state == S_FETCH);
    busy    = (state == S_FETCH) |
              (state == S_DECODE) |
              (state == S_EXEC);
    halted  = (state == S_HALTED);
    retire  = (state == S_EXEC);
    illegal = (state == S_EXEC) & ill_op;
  end

  // Datapath state
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      ir <= '0;
      zf <= 1'b0;
      cf <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_HALTED: begin
          if (start) pc <= '0;
        end
        S_DECODE: ir <= imem_rdata;
        S_EXEC: begin
          pc <= pc_n;
          zf <= zf_n;
          cf <= cf_n;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = pc;
  assign zero_flag  = zf;
  assign carry_flag = cf;

endmodule

// File: tb/tb_proc_seq.sv
// Directed bench for proc_seq with a synchronous imem model.
// Table of programs plus hand sequences for reset/restart/wrap.
module tb_proc_seq;

  localparam int DATA_W = 8;
  localparam int RA_W   = 2;
  localparam int PC_W   = 8;
  localparam int IW     = DATA_W + 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b1;
  logic              imem_en;
  logic [PC_W-1:0]   imem_addr;
  logic [IW-1:0]     imem_rdata = '0;
  logic              busy;
  logic              halted;
  logic              retire;
  logic              illegal;
  logic              zero_flag;
  logic              carry_flag;
  logic [RA_W-1:0]   dbg_addr = '0;
  logic [DATA_W-1:0] dbg_data;

  proc_seq #(
    .DATA_W (DATA_W),
    .RA_W   (RA_W),
    .PC_W   (PC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .busy       (busy),
    .halted     (halted),
    .retire     (retire),
    .illegal    (illegal),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] imem [256];

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem[imem_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0][15:0] prog;
    logic [3:0][7:0]  regs;
    logic             z;
    logic             c;
    int               ret;
    int               ill;
    logic [7:0]       pc;
    int               cyc;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [7:0][15:0] mkp(
    input logic [15:0] w0 = 16'h7000, input logic [15:0] w1 = 16'h7000,
    input logic [15:0] w2 = 16'h7000, input logic [15:0] w3 = 16'h7000,
    input logic [15:0] w4 = 16'h7000, input logic [15:0] w5 = 16'h7000,
    input logic [15:0] w6 = 16'h7000, input logic [15:0] w7 = 16'h7000);
    return {w7, w6, w5, w4, w3, w2, w1, w0};
  endfunction

  function automatic vec_t mk(input logic [7:0][15:0] p,
                              input logic [3:0][7:0] r,
                              input logic z, input logic c,
                              input int ret, input int ill,
                              input logic [7:0] pc, input int cyc);
    vec_t v;
    v.prog = p; v.regs = r; v.z = z; v.c = c;
    v.ret = ret; v.ill = ill; v.pc = pc; v.cyc = cyc;
    return v;
  endfunction

  task automatic load_prog(input logic [7:0][15:0] p);
    for (int i = 0; i < 256; i++) imem[i] = 16'h7000;
    for (int i = 0; i < 8; i++) imem[i] = p[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_halt(output int cyc, output int ret,
                             output int ill, output int bad);
    cyc = 0; ret = 0; ill = 0; bad = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!halted && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (retire) ret++;
      if (illegal) ill++;
      if (illegal && !retire) bad++;
    end
  endtask

  task automatic check_reg(input string name, input int r,
                           input logic [7:0] exp);
    dbg_addr = RA_W'(r);
    #1;
    check($sformatf("%s_r%0d", name, r), 32'(dbg_data), 32'(exp));
  endtask

  initial begin
    int cyc, ret, ill, bad, cnt;

    for (int i = 0; i < 256; i++) imem[i] = 16'h7000;

    vecs[0] = mk(mkp(16'h8005, 16'h8103, 16'h0201),
                 {8'h00, 8'h08, 8'h03, 8'h05}, 0, 0, 4, 0, 8'h03, 12);
    vecs[1] = mk(mkp(16'h8003, 16'h8105, 16'h1201),
                 {8'h00, 8'hFE, 8'h05, 8'h03}, 0, 1, 4, 0, 8'h03, 12);
    vecs[2] = mk(mkp(16'h8003, 16'h8103, 16'h1201),
                 {8'h00, 8'h00, 8'h03, 8'h03}, 1, 0, 4, 0, 8'h03, 12);
    vecs[3] = mk(mkp(16'h80FF, 16'h8101, 16'h0201),
                 {8'h00, 8'h00, 8'h01, 8'hFF}, 1, 1, 4, 0, 8'h03, 12);
    vecs[4] = mk(mkp(16'h8003, 16'hB000, 16'hE004, 16'hF001),
                 {8'h00, 8'h00, 8'h00, 8'h00}, 1, 0, 10, 0, 8'h04, 30);
    vecs[5] = mk(mkp(16'h5000),
                 {8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 2, 1, 8'h01, 6);
    vecs[6] = mk(mkp(16'h80F0, 16'h813C, 16'h2201, 16'h3301, 16'hA300),
                 {8'hFD, 8'h30, 8'h3C, 8'hF0}, 0, 0, 6, 0, 8'h05, 18);
    vecs[7] = mk(mkp(16'h81FF, 16'hA100),
                 {8'h00, 8'h00, 8'h00, 8'h00}, 1, 1, 3, 0, 8'h02, 9);
    vecs[8] = mk(mkp(16'h8007, 16'h0000, 16'h0000),
                 {8'h00, 8'h00, 8'h00, 8'h1C}, 0, 0, 4, 0, 8'h03, 12);

    // Reset with start held high: reset wins, everything reads 0.
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_imem_en", 32'(imem_en), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_retire", 32'(retire), 0);
    check("rst_flags", 32'({zero_flag, carry_flag, illegal}), 0);
    check_reg("rst", 0, 8'h00);
    rst = 1'b0;
    start = 1'b0;

    for (int v = 0; v < 9; v++) begin
      string nm;
      nm = $sformatf("v%0d", v);
      load_prog(vecs[v].prog);
      do_reset();
      run_to_halt(cyc, ret, ill, bad);
      check({nm, "_halted"}, 32'(halted), 1);
      check({nm, "_cycles"}, 32'(cyc), 32'(vecs[v].cyc));
      check({nm, "_retire"}, 32'(ret), 32'(vecs[v].ret));
      check({nm, "_illegal"}, 32'(ill), 32'(vecs[v].ill));
      check({nm, "_ill_coinc"}, 32'(bad), 0);
      check({nm, "_pc"}, 32'(imem_addr), 32'(vecs[v].pc));
      check({nm, "_z"}, 32'(zero_flag), 32'(vecs[v].z));
      check({nm, "_c"}, 32'(carry_flag), 32'(vecs[v].c));
      for (int r = 0; r < 4; r++) check_reg(nm, r, vecs[v].regs[r]);
      if (v == 4) begin
        // Restart from HALTED must begin again at pc 0.
        run_to_halt(cyc, ret, ill, bad);
        check("restart_retire", 32'(ret), 10);
        check("restart_pc", 32'(imem_addr), 4);
        check_reg("restart", 0, 8'h00);
      end
    end

    // Reset during EXEC of ADD R2,R0,R1 discards the write.
    load_prog(vecs[0].prog);
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 50 && cnt < 3; k++) begin
      @(negedge clk);
      if (retire) cnt++;
    end
    check("exec_rst_reached", 32'(cnt), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("exec_rst_busy", 32'(busy), 0);
    check("exec_rst_pc", 32'(imem_addr), 0);
    check_reg("exec_rst", 2, 8'h00);
    check_reg("exec_rst", 0, 8'h00);

    // Start held during execution is ignored.
    load_prog(vecs[0].prog);
    do_reset();
    start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!halted && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 6) start = 1'b0;
    end
    check("busy_start_cycles", 32'(cyc), 12);
    check_reg("busy_start", 2, 8'h08);

    // Jump to top of PC space and halt there.
    for (int i = 0; i < 256; i++) imem[i] = 16'h7000;
    imem[0] = 16'hF0FF;
    do_reset();
    run_to_halt(cyc, ret, ill, bad);
    check("jmpff_halted", 32'(halted), 1);
    check("jmpff_pc", 32'(imem_addr), 32'h0FF);
    check("jmpff_illegal", 32'(ill), 0);
    check("jmpff_retire", 32'(ret), 2);

    // Non-jump at 0xFF wraps pc to 0.
    imem[8'hFF] = 16'h8107;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 50 && cnt < 2; k++) begin
      @(negedge clk);
      if (retire) cnt++;
    end
    check("wrap_reached", 32'(cnt), 2);
    @(negedge clk);
    check("wrap_fetch", 32'(imem_en), 1);
    check("wrap_pc", 32'(imem_addr), 0);
    check_reg("wrap", 1, 8'h07);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
